// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Elastic pipeline-stage register with a 2-entry skid buffer. It carries a
//   destination-register index and NUM_F packed DATA_W-bit payload fields.
//   in_ready comes straight from a flop, so no combinational ready path runs
//   back through this stage. The stage still sustains one transfer per cycle.
//   Ports:
//     clk, reset          clock; synchronous active-high reset
//     flush               synchronous drop of all held entries (bubble insert)
//     in_valid/in_ready   upstream handshake (in_ready registered)
//     in_wreg/in_data     upstream entry
//     out_valid/out_ready downstream handshake
//     out_wreg/out_data   head entry
//     stall_cnt/clr_cnt   saturating count of cycles with out_valid & ~out_ready; sync clear
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int NUM_F  = 4,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [REG_W-1:0]        in_wreg,
   input  logic [NUM_F*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [REG_W-1:0]        out_wreg,
   output logic [NUM_F*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]        stall_cnt,
   input  logic                    clr_cnt
);
   localparam int PW = NUM_F * DATA_W;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [REG_W-1:0] head_wreg_q, head_wreg_d, skid_wreg_q, skid_wreg_d;
   logic [PW-1:0]    head_data_q, head_data_d, skid_data_q, skid_data_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, pop, vld;

   assign vld    = (state_q != EMPTY);
   assign accept = in_valid & in_ready_q;
   assign pop    = vld & out_ready;

   // state register
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_wreg_q <= head_wreg_d;
      head_data_q <= head_data_d;
      skid_wreg_q <= skid_wreg_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
   end

   // next-state logic; reset and flush both collapse to EMPTY
   always_comb begin
      state_d = state_q;
      if (reset || flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
               if (accept && !pop)      state_d = TWO;
               else if (pop && !accept) state_d = EMPTY;
            end
            TWO:   if (pop) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
      // registered ready is exactly "next state has room"
      in_ready_d = (state_d != TWO);
   end

   // datapath and counter updates
   always_comb begin
      head_wreg_d = head_wreg_q;
      head_data_d = head_data_q;
      skid_wreg_d = skid_wreg_q;
      skid_data_d = skid_data_q;
      if (reset || flush) begin
         // zeroed so downstream sees a clean bubble
         head_wreg_d = '0;
         head_data_d = '0;
         skid_wreg_d = '0;
         skid_data_d = '0;
      end else begin
         case (state_q)
            EMPTY: if (accept) begin
               head_wreg_d = in_wreg;
               head_data_d = in_data;
            end
            ONE: begin
               if (accept && pop) begin
                  head_wreg_d = in_wreg;
                  head_data_d = in_data;
               end else if (accept) begin
                  skid_wreg_d = in_wreg;
                  skid_data_d = in_data;
               end
               // pop to EMPTY leaves the stale head; out_valid gates it
            end
            TWO: if (pop) begin
               head_wreg_d = skid_wreg_q;
               head_data_d = skid_data_q;
            end
            default: ;
         endcase
      end

      cnt_d = cnt_q;
      if (reset || clr_cnt)
         cnt_d = '0;
      else if (vld && !out_ready && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   // outputs
   always_comb begin
      out_valid = vld;
      in_ready  = in_ready_q;
      out_wreg  = head_wreg_q;
      out_data  = head_data_q;
      stall_cnt = cnt_q;
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Scoreboard bench for pipe_stage_skid. A queue holds the entries the stage
//   should contain; each cycle the outputs are compared with the queue head
//   and the model counters. A second instance with CNT_W=3 shares all inputs
//   and exercises counter saturation.
module tb_pipe_stage_skid;
   localparam int DATA_W = 32, NUM_F = 4, REG_W = 5, PW = DATA_W * NUM_F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, flush, in_valid, out_ready, clr_cnt;
   logic [REG_W-1:0] in_wreg;
   logic [PW-1:0]    in_data;
   logic             in_ready, out_valid, in_ready_s, out_valid_s;
   logic [REG_W-1:0] out_wreg, out_wreg_s;
   logic [PW-1:0]    out_data, out_data_s;
   logic [15:0]      stall_cnt;
   logic [2:0]       stall_cnt_s;

   pipe_stage_skid #(.DATA_W(DATA_W), .NUM_F(NUM_F), .REG_W(REG_W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_wreg(in_wreg), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_wreg(out_wreg), .out_data(out_data), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt));

   pipe_stage_skid #(.DATA_W(DATA_W), .NUM_F(NUM_F), .REG_W(REG_W), .CNT_W(3)) dut_s (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_wreg(in_wreg), .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_wreg(out_wreg_s), .out_data(out_data_s), .stall_cnt(stall_cnt_s), .clr_cnt(clr_cnt));

   typedef struct packed {
      logic [REG_W-1:0] wreg;
      logic [PW-1:0]    data;
   } ent_t;

   ent_t        sb[$];
   bit          zeroed;
   int unsigned m_cnt, m_cnt_s;
   int          n_chk = 0, n_fail = 0;
   bit          prev_stall;
   ent_t        prev_out;

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Called just after a posedge: compare outputs with the model, then drive
   // this cycle's inputs, advance the model and move to the next edge.
   task automatic cyc(input bit iv, input logic [REG_W-1:0] w, input logic [PW-1:0] d,
                      input bit ordy, input bit fl, input bit clr, input bit rst);
      bit   acc, pp;
      ent_t cur;
      chk("out_valid", PW'(out_valid), PW'(sb.size() != 0));
      chk("in_ready",  PW'(in_ready),  PW'(sb.size() < 2));
      chk("stall_cnt", PW'(stall_cnt), PW'(m_cnt));
      chk("stall_cnt_s", PW'(stall_cnt_s), PW'(m_cnt_s));
      cur.wreg = out_wreg;
      cur.data = out_data;
      if (sb.size() != 0) begin
         chk("head_wreg", PW'(out_wreg), PW'(sb[0].wreg));
         chk("head_data", out_data, sb[0].data);
      end else if (zeroed) begin
         chk("bubble_wreg", PW'(out_wreg), '0);
         chk("bubble_data", out_data, '0);
      end
      if (prev_stall && sb.size() != 0)
         chk("hold", PW'(cur), PW'(prev_out));

      reset = rst; flush = fl; in_valid = iv; in_wreg = w; in_data = d;
      out_ready = ordy; clr_cnt = clr;

      acc = iv && (sb.size() < 2);
      pp  = (sb.size() != 0) && ordy;
      prev_stall = (sb.size() != 0) && !ordy && !rst && !fl;
      prev_out   = cur;
      if (rst || clr) m_cnt = 0;
      else if (sb.size() != 0 && !ordy && m_cnt != 16'hffff) m_cnt++;
      if (rst || clr) m_cnt_s = 0;
      else if (sb.size() != 0 && !ordy && m_cnt_s != 7) m_cnt_s++;
      if (rst || fl) begin
         sb.delete();
         zeroed = 1'b1;
      end else begin
         if (pp) begin
            void'(sb.pop_front());
            zeroed = 1'b0;
         end
         if (acc) sb.push_back('{wreg: w, data: d});
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_wreg = 5'd9; in_data = '1;
      out_ready = 1'b0; clr_cnt = 1'b0;
      zeroed = 1'b1; m_cnt = 0; m_cnt_s = 0; prev_stall = 1'b0; prev_out = '0;
      // reset held 2 cycles with in_valid high
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_out_valid", PW'(out_valid), '0);
      chk("rst_out_wreg",  PW'(out_wreg),  '0);
      chk("rst_out_data",  out_data,       '0);
      chk("rst_in_ready",  PW'(in_ready),  PW'(1'b1));
      chk("rst_stall_cnt", PW'(stall_cnt), '0);

      // streaming: 1-cycle latency, back-to-back
      for (int i = 1; i <= 8; i++) begin
         cyc(1, REG_W'(i), PW'(i * 32'h1111), 1, 0, 0, 0);
         chk("stream_wreg", PW'(out_wreg), PW'(i));
         chk("stream_rdy",  PW'(in_ready), PW'(1'b1));
      end
      cyc(0, 0, 0, 1, 0, 0, 0);

      // backpressure: A then B into a stalled stage
      cyc(1, 5'd3, PW'(32'hAAAA), 0, 0, 0, 0);
      cyc(1, 5'd4, PW'(32'hBBBB), 0, 0, 0, 0);
      chk("bp_in_ready", PW'(in_ready), '0);
      chk("bp_head",     PW'(out_wreg), PW'(5'd3));
      cyc(1, 5'd5, PW'(32'hCCCC), 0, 0, 0, 0);   // refused, in_ready=0
      chk("bp_hold", PW'(out_wreg), PW'(5'd3));
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("bp_A_then_B", PW'(out_wreg), PW'(5'd4));
      chk("bp_rdy_back", PW'(in_ready), PW'(1'b1));
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("bp_drained", PW'(out_valid), '0);

      // flush in TWO with C offered
      cyc(1, 5'd3, PW'(32'h1), 0, 0, 0, 0);
      cyc(1, 5'd4, PW'(32'h2), 0, 0, 0, 0);
      cyc(1, 5'd7, PW'(32'h3), 0, 1, 0, 0);
      chk("fl_valid", PW'(out_valid), '0);
      chk("fl_wreg",  PW'(out_wreg),  '0);
      chk("fl_ready", PW'(in_ready),  PW'(1'b1));
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("fl_no_C",  PW'(out_valid), '0);

      // counter: clear, load one entry, stall
      cyc(1, 5'd2, PW'(32'h22), 0, 0, 1, 0);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0, 0);
      chk("cnt9",   PW'(stall_cnt),   PW'(16'd9));
      chk("cnt_sat", PW'(stall_cnt_s), PW'(3'd7));
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("cnt10",  PW'(stall_cnt),   PW'(16'd10));
      cyc(0, 0, 0, 0, 0, 1, 0);                  // clear wins over increment
      chk("cnt_clr",  PW'(stall_cnt),   '0);
      chk("cnt_clr_s", PW'(stall_cnt_s), '0);
      cyc(0, 0, 0, 1, 0, 0, 0);

      // random traffic against the scoreboard
      for (int i = 0; i < 10000; i++) begin
         cyc($urandom_range(0, 1) == 1, REG_W'($urandom), rnd_data(),
             $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
      end
      cyc(0, 0, 0, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
